// File: rtl/rvfi_reorder_window.sv
// rvfi_reorder_window
//   Collects up to NRET out-of-order RVFI retirements per cycle into a WINDOW-entry
//   buffer indexed by the low bits of rvfi_order. It re-emits them one per cycle in
//   strictly increasing order. Rollbacks invalidate younger entries and are forwarded
//   in-band as a one-cycle marker.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   in_valid/order/insn/trap/intr  per-channel retirement bus (channel c in slice c)
//   in_rollback_valid/order        rollback request; order is the first invalidated
//   out_valid/order/insn/trap/intr single-channel in-order retirement stream
//   out_rollback_valid             rollback marker; out_order carries its order
//   next_order          order expected next at the head
//   occupancy           number of valid buffered entries
//   err_dup, err_window sticky error flags (slot collision, order outside window)
module rvfi_reorder_window #(
  parameter int unsigned NRET   = 2,
  parameter int unsigned ILEN   = 32,
  parameter int unsigned WINDOW = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NRET-1:0]          in_valid,
  input  logic [64*NRET-1:0]       in_order,
  input  logic [ILEN*NRET-1:0]     in_insn,
  input  logic [NRET-1:0]          in_trap,
  input  logic [NRET-1:0]          in_intr,
  input  logic                     in_rollback_valid,
  input  logic [63:0]              in_rollback_order,
  output logic                     out_valid,
  output logic [63:0]              out_order,
  output logic [ILEN-1:0]          out_insn,
  output logic                     out_trap,
  output logic                     out_intr,
  output logic                     out_rollback_valid,
  output logic [63:0]              next_order,
  output logic [$clog2(WINDOW):0]  occupancy,
  output logic                     err_dup,
  output logic                     err_window
);

  localparam int unsigned IW = $clog2(WINDOW);

  logic [WINDOW-1:0] ent_valid_q, ent_valid_d;
  logic [63:0]       ent_order_q [WINDOW];
  logic [63:0]       ent_order_d [WINDOW];
  logic [ILEN-1:0]   ent_insn_q  [WINDOW];
  logic [ILEN-1:0]   ent_insn_d  [WINDOW];
  logic [WINDOW-1:0] ent_trap_q, ent_trap_d;
  logic [WINDOW-1:0] ent_intr_q, ent_intr_d;

  logic [63:0]       next_order_q, next_order_d;
  logic              out_valid_q, out_valid_d;
  logic              out_rb_q, out_rb_d;
  logic [63:0]       out_order_q, out_order_d;
  logic [ILEN-1:0]   out_insn_q, out_insn_d;
  logic              out_trap_q, out_trap_d;
  logic              out_intr_q, out_intr_d;
  logic              err_dup_q, err_dup_d;
  logic              err_window_q, err_window_d;

  logic [63:0]       base;
  logic              drain;
  logic [IW-1:0]     head;

  assign head = next_order_q[IW-1:0];

  always_comb begin
    ent_valid_d  = ent_valid_q;
    ent_order_d  = ent_order_q;
    ent_insn_d   = ent_insn_q;
    ent_trap_d   = ent_trap_q;
    ent_intr_d   = ent_intr_q;
    out_valid_d  = 1'b0;
    out_rb_d     = 1'b0;
    out_order_d  = out_order_q;
    out_insn_d   = out_insn_q;
    out_trap_d   = out_trap_q;
    out_intr_d   = out_intr_q;
    err_dup_d    = err_dup_q;
    err_window_d = err_window_q;
    base         = next_order_q;
    drain        = 1'b0;

    if (in_rollback_valid) begin
      for (int unsigned i = 0; i < WINDOW; i++) begin
        if (ent_valid_q[i] && (ent_order_q[i] >= in_rollback_order)) begin
          ent_valid_d[i] = 1'b0;
        end
      end
      if (in_rollback_order < next_order_q) begin
        base = in_rollback_order;
      end
      out_rb_d    = 1'b1;
      out_order_d = in_rollback_order;
    end else if (ent_valid_q[head] && (ent_order_q[head] == next_order_q)) begin
      drain             = 1'b1;
      out_valid_d       = 1'b1;
      out_order_d       = ent_order_q[head];
      out_insn_d        = ent_insn_q[head];
      out_trap_d        = ent_trap_q[head];
      out_intr_d        = ent_intr_q[head];
      ent_valid_d[head] = 1'b0;
    end

    // Writes are windowed against the post-rollback, pre-increment head. Walking
    // channels upward lets a lower channel claim a slot before a higher one.
    for (int unsigned c = 0; c < NRET; c++) begin
      if (in_valid[c]) begin
        if ((in_order[c*64 +: 64] >= base) &&
            ((in_order[c*64 +: 64] - base) < 64'(WINDOW))) begin
          if (ent_valid_d[in_order[c*64 +: IW]]) begin
            err_dup_d = 1'b1;
          end else begin
            ent_valid_d[in_order[c*64 +: IW]] = 1'b1;
            ent_order_d[in_order[c*64 +: IW]] = in_order[c*64 +: 64];
            ent_insn_d[in_order[c*64 +: IW]]  = in_insn[c*ILEN +: ILEN];
            ent_trap_d[in_order[c*64 +: IW]]  = in_trap[c];
            ent_intr_d[in_order[c*64 +: IW]]  = in_intr[c];
          end
        end else begin
          err_window_d = 1'b1;
        end
      end
    end

    next_order_d = base + {63'd0, drain};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid_q  <= '0;
      next_order_q <= '0;
      out_valid_q  <= 1'b0;
      out_rb_q     <= 1'b0;
      out_order_q  <= '0;
      out_insn_q   <= '0;
      out_trap_q   <= 1'b0;
      out_intr_q   <= 1'b0;
      err_dup_q    <= 1'b0;
      err_window_q <= 1'b0;
    end else begin
      ent_valid_q  <= ent_valid_d;
      next_order_q <= next_order_d;
      out_valid_q  <= out_valid_d;
      out_rb_q     <= out_rb_d;
      out_order_q  <= out_order_d;
      out_insn_q   <= out_insn_d;
      out_trap_q   <= out_trap_d;
      out_intr_q   <= out_intr_d;
      err_dup_q    <= err_dup_d;
      err_window_q <= err_window_d;
    end
  end

  // Payload needs no reset: it is only ever read behind a valid bit.
  always_ff @(posedge clock) begin
    ent_order_q <= ent_order_d;
    ent_insn_q  <= ent_insn_d;
    ent_trap_q  <= ent_trap_d;
    ent_intr_q  <= ent_intr_d;
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < WINDOW; i++) begin
      occupancy = occupancy + {{IW{1'b0}}, ent_valid_q[i]};
    end
  end

  assign out_valid          = out_valid_q;
  assign out_rollback_valid = out_rb_q;
  assign out_order          = out_order_q;
  assign out_insn           = out_insn_q;
  assign out_trap           = out_trap_q;
  assign out_intr           = out_intr_q;
  assign next_order         = next_order_q;
  assign err_dup            = err_dup_q;
  assign err_window         = err_window_q;

endmodule

// File: tb/tb_rvfi_reorder_window.sv
// Bench for rvfi_reorder_window: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a map-based model of the window.
module tb_rvfi_reorder_window;

  localparam int unsigned NRET   = 2;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned WINDOW = 8;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NRET-1:0]         in_valid;
  logic [64*NRET-1:0]      in_order;
  logic [ILEN*NRET-1:0]    in_insn;
  logic [NRET-1:0]         in_trap;
  logic [NRET-1:0]         in_intr;
  logic                    in_rollback_valid;
  logic [63:0]             in_rollback_order;
  logic                    out_valid;
  logic [63:0]             out_order;
  logic [ILEN-1:0]         out_insn;
  logic                    out_trap;
  logic                    out_intr;
  logic                    out_rollback_valid;
  logic [63:0]             next_order;
  logic [$clog2(WINDOW):0] occupancy;
  logic                    err_dup;
  logic                    err_window;

  rvfi_reorder_window #(.NRET(NRET), .ILEN(ILEN), .WINDOW(WINDOW)) dut (
    .clock              (clock),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_order           (in_order),
    .in_insn            (in_insn),
    .in_trap            (in_trap),
    .in_intr            (in_intr),
    .in_rollback_valid  (in_rollback_valid),
    .in_rollback_order  (in_rollback_order),
    .out_valid          (out_valid),
    .out_order          (out_order),
    .out_insn           (out_insn),
    .out_trap           (out_trap),
    .out_intr           (out_intr),
    .out_rollback_valid (out_rollback_valid),
    .next_order         (next_order),
    .occupancy          (occupancy),
    .err_dup            (err_dup),
    .err_window         (err_window)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: buffered retirements keyed directly by their order.
  typedef struct packed {
    logic [ILEN-1:0] insn;
    logic            trap;
    logic            intr;
  } ent_t;
  typedef bit [63:0] key_t;

  ent_t            mem [key_t];
  logic [63:0]     m_next, m_order;
  logic [ILEN-1:0] m_insn;
  logic            m_ov, m_rbv, m_trap, m_intr, m_edup, m_ewin;

  task automatic model_step();
    logic [63:0] base, o;
    key_t        dels[$];
    ent_t        e;
    bit          drained;
    if (reset) begin
      mem.delete();
      m_next = '0; m_order = '0; m_insn = '0;
      m_ov = 0; m_rbv = 0; m_trap = 0; m_intr = 0; m_edup = 0; m_ewin = 0;
      return;
    end
    base    = m_next;
    drained = 0;
    m_ov    = 0;
    m_rbv   = 0;
    if (in_rollback_valid) begin
      foreach (mem[k]) if (k >= in_rollback_order) dels.push_back(k);
      foreach (dels[i]) mem.delete(dels[i]);
      if (in_rollback_order < m_next) base = in_rollback_order;
      m_rbv   = 1;
      m_order = in_rollback_order;
    end else if (mem.exists(base)) begin
      e = mem[base];
      m_ov = 1; m_order = base; m_insn = e.insn; m_trap = e.trap; m_intr = e.intr;
      mem.delete(base);
      drained = 1;
    end
    for (int c = 0; c < NRET; c++) begin
      if (in_valid[c]) begin
        o = in_order[c*64 +: 64];
        if (o >= base && o < base + WINDOW) begin
          if (mem.exists(o)) m_edup = 1;
          else mem[o] = '{insn: in_insn[c*ILEN +: ILEN], trap: in_trap[c], intr: in_intr[c]};
        end else begin
          m_ewin = 1;
        end
      end
    end
    m_next = base + (drained ? 64'd1 : 64'd0);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_rollback_valid", 64'(out_rollback_valid), 64'(m_rbv));
      chk("out_order", out_order, m_order);
      chk("out_insn", 64'(out_insn), 64'(m_insn));
      chk("out_trap", 64'(out_trap), 64'(m_trap));
      chk("out_intr", 64'(out_intr), 64'(m_intr));
      chk("next_order", next_order, m_next);
      chk("occupancy", 64'(occupancy), 64'(mem.size()));
      chk("err_dup", 64'(err_dup), 64'(m_edup));
      chk("err_window", 64'(err_window), 64'(m_ewin));
    end
  end

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic clear_in();
    in_valid = '0; in_order = '0; in_insn = '0; in_trap = '0; in_intr = '0;
    in_rollback_valid = 1'b0; in_rollback_order = '0;
  endtask

  task automatic put(input int c, input logic [63:0] o, input logic [ILEN-1:0] insn);
    in_valid[c]              = 1'b1;
    in_order[c*64 +: 64]     = o;
    in_insn[c*ILEN +: ILEN]  = insn;
    in_trap[c]               = o[0];
    in_intr[c]               = o[1];
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_seq[4];
    logic [63:0] lo, o, r;
    int          cnt3;
    clear_in();
    reset  = 1'b1;
    chk_en = 1'b1;
    step();
    chk("reset_out_order", out_order, 64'd0);
    chk("reset_next_order", next_order, 64'd0);
    reset = 1'b0;

    // In-order stream.
    put(0, 0, 32'h1000); put(1, 1, 32'h1001); step();
    clear_in(); put(0, 2, 32'h1002); put(1, 3, 32'h1003); step();
    chk("inorder_valid0", 64'(out_valid), 64'd1);
    chk("inorder_order0", out_order, 64'd0);
    clear_in();
    exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("inorder_order", out_order, exp_seq[i]);
    end
    step();
    chk("inorder_next", next_order, 64'd4);
    chk("inorder_occ", 64'(occupancy), 64'd0);

    // Out-of-order arrival 2, 1, 0.
    do_reset();
    put(0, 2, 32'h2002); step();
    clear_in(); put(0, 1, 32'h2001); step();
    clear_in(); put(0, 0, 32'h2000); step();
    chk("ooo_idle", 64'(out_valid), 64'd0);
    clear_in();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ooo_valid", 64'(out_valid), 64'd1);
      chk("ooo_order", out_order, 64'(i));
    end

    // Duplicate on both channels in one cycle.
    do_reset();
    put(0, 3, 32'hAAAA_0003); put(1, 3, 32'hBBBB_0003); step();
    chk("dup_flag", 64'(err_dup), 64'd1);
    clear_in(); put(0, 0, 32'h0); put(1, 1, 32'h1); step();
    clear_in(); put(0, 2, 32'h2); step();
    clear_in();
    cnt3 = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid && out_order == 64'd3) begin
        cnt3++;
        chk("dup_insn", 64'(out_insn), 64'h0000_0000_AAAA_0003);
      end
      step();
    end
    chk("dup_count", 64'(cnt3), 64'd1);

    // Window bound.
    do_reset();
    put(0, 8, 32'h8); step();
    chk("win_flag", 64'(err_window), 64'd1);
    chk("win_occ", 64'(occupancy), 64'd0);
    clear_in(); put(0, 7, 32'h7); step();
    chk("win_accept", 64'(occupancy), 64'd1);

    // Rollback.
    do_reset();
    put(0, 0, 32'h0); put(1, 1, 32'h1); step();
    clear_in(); put(0, 2, 32'h2); put(1, 3, 32'h3); step();
    clear_in(); put(0, 4, 32'h4); step();
    chk("rb_pre_order", out_order, 64'd1);
    clear_in(); in_rollback_valid = 1'b1; in_rollback_order = 64'd2; step();
    chk("rb_marker", 64'(out_rollback_valid), 64'd1);
    chk("rb_order", out_order, 64'd2);
    chk("rb_next", next_order, 64'd2);
    chk("rb_occ", 64'(occupancy), 64'd0);
    clear_in(); put(0, 2, 32'h2222); step();
    clear_in(); step();
    chk("rb_reissue_valid", 64'(out_valid), 64'd1);
    chk("rb_reissue_order", out_order, 64'd2);

    // Reset mid-operation.
    do_reset();
    put(0, 1, 32'h1); put(1, 1, 32'h11); step();
    clear_in(); put(0, 2, 32'h2); put(1, 3, 32'h3); step();
    clear_in(); put(0, 4, 32'h4); put(1, 5, 32'h5); step();
    chk("mid_occ_pre", 64'(occupancy), 64'd5);
    do_reset();
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_occ", 64'(occupancy), 64'd0);
    chk("mid_next", next_order, 64'd0);
    chk("mid_dup", 64'(err_dup), 64'd0);
    put(0, 0, 32'h5A5A); step();
    clear_in(); step();
    chk("mid_emit", 64'(out_valid), 64'd1);
    chk("mid_emit_order", out_order, 64'd0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clear_in();
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) begin
        r = (m_next >= 3) ? m_next - 3 : 64'd0;
        in_rollback_valid = 1'b1;
        in_rollback_order = r + 64'($urandom_range(0, WINDOW + 3));
      end
      lo = (m_next >= 2) ? m_next - 2 : 64'd0;
      for (int c = 0; c < NRET; c++) begin
        if ($urandom_range(0, 9) < 6) begin
          o = lo + 64'($urandom_range(0, WINDOW + 3));
          // Skip re-presenting the order that drains on this same edge.
          if (!(!in_rollback_valid && o == m_next && mem.exists(m_next)))
            put(c, o, $urandom());
        end
      end
      step();
    end
    reset = 1'b0;
    clear_in();
    step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfi_reorder_window.md
Name: rvfi_reorder_window

Overview:
Sits directly upstream of the RVFI cover/consistency checkers. Accepts up to NRET retirements per cycle on the multi-channel RVFI bus, in arbitrary order within a bounded window. Re-emits them as a single-channel stream in strictly increasing rvfi_order, with rollback forwarded in-band. Downstream counters and cover statements then see one retirement per cycle, in program order.

Parameters:
NRET, 2, number of retirement channels on the input bus
ILEN, 32, instruction width in bits
WINDOW, 8, reorder window depth in entries; power of two, at least 2

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  NRET  per-channel retirement valid
in_order  in  64*NRET  per-channel rvfi_order; channel c at [c*64 +: 64]
in_insn  in  ILEN*NRET  per-channel instruction word
in_trap  in  NRET  per-channel trap flag
in_intr  in  NRET  per-channel intr flag
in_rollback_valid  in  1  rollback request
in_rollback_order  in  64  first order value invalidated by the rollback
out_valid  out  1  emitted retirement valid
out_order  out  64  order of emitted retirement, or rollback order when out_rollback_valid=1
out_insn  out  ILEN  instruction word of emitted retirement
out_trap  out  1  trap flag of emitted retirement
out_intr  out  1  intr flag of emitted retirement
out_rollback_valid  out  1  single-cycle rollback marker
next_order  out  64  order expected next at the head
occupancy  out  $clog2(WINDOW)+1  number of valid buffered entries
err_dup  out  1  sticky: write to an occupied slot
err_window  out  1  sticky: input order outside the window

Behaviour:
- Reset (clock edge with reset=1) clears the following. The same applies to reset asserted mid-operation: all buffered entries are discarded, no output is produced for them.
  - all entries empty
  - next_order=0, occupancy=0
  - out_valid=0, out_rollback_valid=0, out_order=0, out_insn=0, out_trap=0, out_intr=0
  - err_dup=0, err_window=0
- Storage: WINDOW entries, each holding {valid, order[63:0], insn, trap, intr}.
  - Slot index = order[$clog2(WINDOW)-1:0].
- Per-edge order of operations (reset=0):
  1. Rollback.
  2. Drain, only if no rollback this cycle.
  3. Input writes, checked against next_order after step 1 and before step 2's increment.
- Rollback, with R = in_rollback_order:
  - Every entry with order >= R is invalidated.
  - If R < next_order, next_order := R; otherwise next_order is unchanged.
  - Next cycle: out_rollback_valid=1, out_order=R, out_valid=0.
- Drain:
  - Condition: the entry at slot(next_order) is valid and its stored order equals next_order.
  - Action: load out_* from the entry, out_valid=1 next cycle, clear the entry, next_order+1.
  - Otherwise out_valid=0 next cycle.
  - At most one drain per cycle.
- Input write for channel c with in_valid[c]=1:
  - Accepted iff next_order <= order < next_order+WINDOW, using 64-bit unsigned compare with no wrap.
  - Otherwise dropped and err_window:=1.
  - An accepted write to a slot that is still valid after the drain sets err_dup:=1; the existing entry is kept.
  - Two channels hitting the same slot in one cycle: the lowest channel index wins, err_dup:=1.
- Drain and write on the same slot in one cycle: the write is out of window (order = next_order+WINDOW before increment), so it is dropped with err_window.
- Latency: a retirement presented in cycle t whose order equals next_order is visible on out_* in cycle t+2. Write at end of t, drain at end of t+1.
- out_* fields hold their last values when out_valid=0 and out_rollback_valid=0. Only the two valid bits are meaningful.
- occupancy = accepted writes minus drains minus rollback invalidations, updated every edge.
- Error flags are sticky until reset.

Test Plan:
- In-order stream, NRET=2, orders 0,1 in cycle 0 and 2,3 in cycle 1 -> out_order 0,1,2,3 in cycles 2..5 with out_valid=1; next_order=4; occupancy=0 afterwards.
- Out-of-order: cycle 0 order 2, cycle 1 order 1, cycle 2 order 0 -> out_valid=0 through cycle 3; out_order 0,1,2 in cycles 4,5,6.
- Duplicate: order 3 on both channels in cycle 0 -> err_dup=1; channel 0's insn stored; order 3 emitted exactly once after 0..2 arrive.
- Window bound, WINDOW=8, next_order=0: order 8 presented -> dropped, err_window=1, occupancy unchanged; order 7 accepted.
- Rollback: orders 0..4 buffered with 0,1 already emitted; in_rollback_valid=1 with R=2 -> next cycle out_rollback_valid=1 and out_order=2; next_order=2; occupancy=0. A re-presented order 2 is emitted two cycles later.
- Reset mid-operation with 5 entries buffered and err_dup=1 -> next cycle out_valid=0, occupancy=0, next_order=0, err_dup=0; a subsequent order 0 is emitted normally.
